// File: rtl/dadda_mul_arbiter_if.sv
// Request/response bundle for dadda_mul_arbiter.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface dadda_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_prod;
  logic [ID_W-1:0]   rsp_id;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_prod, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_prod, rsp_id, busy
  );
endinterface

// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: one 8x8 unsigned Dadda multiplier shared by NREQ requesters.
// Round-robin grant, operand stage S1, product stage S2, valid/ready on both sides.
// Optional per-requester grant counters are built when DADDA_ARB_STATS_EN is defined.
module dadda_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef DADDA_ARB_STATS_EN
  input  logic                 stats_clr,
  output logic [16*NREQ-1:0]   grant_cnt,
`endif
  dadda_mul_arbiter_if.slave   bus
);

  // Dadda column compression of the 8x8 partial-product array, reduction
  // heights 6,4,3,2, followed by a final carry-propagate add of two rows.
  function automatic logic [15:0] dadda8(input logic [7:0] a, input logic [7:0] b);
    logic        col [16][16];
    logic        nxt [16][16];
    int          h   [16];
    int          nh  [16];
    int          dseq [4];
    int          k;
    logic [15:0] row0;
    logic [15:0] row1;
    dseq = '{6, 4, 3, 2};
    for (int c = 0; c < 16; c++) begin
      h[c] = 0;
      for (int r = 0; r < 16; r++) col[c][r] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        col[i+j][h[i+j]] = a[i] & b[j];
        h[i+j] += 1;
      end
    end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 16; c++) begin
        nh[c] = 0;
        for (int r = 0; r < 16; r++) nxt[c][r] = 1'b0;
      end
      for (int c = 0; c < 16; c++) begin
        k = 0;
        // Only compress the excess over the target height; carries from the
        // column to the right already count against this column's budget.
        for (int it = 0; it < 8; it++) begin
          if ((h[c] - k) + nh[c] > dseq[s]) begin
            if ((h[c] - k) + nh[c] == dseq[s] + 1) begin
              nxt[c][nh[c]] = col[c][k] ^ col[c][k+1];
              if (c < 15) begin
                nxt[c+1][nh[c+1]] = col[c][k] & col[c][k+1];
                nh[c+1] += 1;
              end
              nh[c] += 1;
              k += 2;
            end else begin
              nxt[c][nh[c]] = col[c][k] ^ col[c][k+1] ^ col[c][k+2];
              if (c < 15) begin
                nxt[c+1][nh[c+1]] = (col[c][k] & col[c][k+1]) |
                                    (col[c][k] & col[c][k+2]) |
                                    (col[c][k+1] & col[c][k+2]);
                nh[c+1] += 1;
              end
              nh[c] += 1;
              k += 3;
            end
          end
        end
        for (int r = 0; r < 16; r++) begin
          if (r >= k && r < h[c]) begin
            nxt[c][nh[c]] = col[c][r];
            nh[c] += 1;
          end
        end
      end
      col = nxt;
      h   = nh;
    end
    for (int c = 0; c < 16; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
    return row0 + row1;
  endfunction

  logic            s1_vld, s2_vld;
  logic [7:0]      s1_a, s1_b;
  logic [ID_W-1:0] s1_id, s2_id;
  logic [15:0]     s2_prod;
  logic [ID_W-1:0] ptr;
  logic [15:0]     mul_prod;
  logic            s2_load, s1_adv, s1_can;
  logic            found, accept;
  logic [ID_W-1:0] grant;
  logic [NREQ-1:0] rdy;

  // The single shared multiplier sits between S1 and S2.
  assign mul_prod = dadda8(s1_a, s1_b);

  assign s2_load = !s2_vld || bus.rsp_ready;
  assign s1_adv  = s1_vld && s2_load;
  assign s1_can  = !s1_vld || s1_adv;

  // Round-robin search from ptr; descending scan lets the nearest requester win.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    grant = '0;
    rdy   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        grant = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
    if (found && s1_can && !rst) rdy[grant] = 1'b1;
  end

  assign accept        = |(bus.req_valid & rdy);
  assign bus.req_ready = rdy;
  assign bus.rsp_valid = s2_vld && !rst;
  assign bus.rsp_prod  = s2_prod;
  assign bus.rsp_id    = s2_id;
  assign bus.busy      = (s1_vld || s2_vld) && !rst;

  // Pipeline control state: stage valids and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      ptr    <= '0;
    end else begin
      if (s2_load) s2_vld <= s1_vld;
      if (s1_can)  s1_vld <= accept;
      if (accept)  ptr    <= (int'(grant) == NREQ - 1) ? '0 : grant + ID_W'(1);
    end
  end

  // S1 operand capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: S1 payload is qualified by s1_vld, so it needs no reset.
    if (!rst && accept) begin
      s1_a  <= bus.req_a[8*int'(grant) +: 8];
      s1_b  <= bus.req_b[8*int'(grant) +: 8];
      s1_id <= grant;
    end
  end

  // S2 product capture; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_prod <= '0;
      s2_id   <= '0;
    end else if (s1_adv) begin
      s2_prod <= mul_prod;
      s2_id   <= s1_id;
    end
  end

`ifdef DADDA_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  // Saturating per-requester accept counters; clear beats increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || stats_clr) cnt_q[i] <= '0;
      else if (accept && grant == ID_W'(i) && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[16*i +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Directed testbench for dadda_mul_arbiter (NREQ=4, ID_W=2).
module tb_dadda_mul_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  dadda_mul_arbiter_if #(.NREQ(4), .ID_W(2)) bus ();

`ifdef DADDA_ARB_STATS_EN
  logic        stats_clr;
  logic [63:0] grant_cnt;
  dadda_mul_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .stats_clr(stats_clr), .grant_cnt(grant_cnt), .bus(bus)
  );
`else
  dadda_mul_arbiter #(.NREQ(4), .ID_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
  endtask

  // One isolated operation: grant, 2-cycle latency, product, then idle.
  task automatic single_op(input string tag, input int id, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp_prod);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    set_op(id, a, b);
    bus.req_valid = oh;
    bus.rsp_ready = 1'b1;
    #1 check({tag, ".ready"}, 64'(bus.req_ready), 64'(oh));
    tick();
    bus.req_valid = '0;
    #1 check({tag, ".s1_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, ".s1_busy"}, 64'(bus.busy), 64'd1);
    tick();
    check({tag, ".valid"}, 64'(bus.rsp_valid), 64'd1);
    check({tag, ".prod"}, 64'(bus.rsp_prod), 64'(exp_prod));
    check({tag, ".id"}, 64'(bus.rsp_id), 64'(id));
    tick();
    check({tag, ".idle_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, ".idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [15:0] rr_prod [4];
    int          n_acc;
    rr_prod = '{16'h0030, 16'h0044, 16'h005A, 16'h0072};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
`ifdef DADDA_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1 check("rst.ready_during", 64'(bus.req_ready), 64'd0);
    tick();
    tick();
    check("rst.valid", 64'(bus.rsp_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.prod", 64'(bus.rsp_prod), 64'd0);
    check("rst.id", 64'(bus.rsp_id), 64'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    single_op("single", 2, 8'h0D, 8'h0B, 16'h008F);
    single_op("ff_ff", 0, 8'hFF, 8'hFF, 16'hFE01);
    single_op("00_a5", 1, 8'h00, 8'hA5, 16'h0000);
    single_op("80_02", 2, 8'h80, 8'h02, 16'h0100);
    single_op("01_37", 3, 8'h01, 8'h37, 16'h0037);

    // Round robin: pointer is back at 0, all four requesters valid.
    for (int i = 0; i < 4; i++) set_op(i, 8'(8'h10 + i), 8'(8'h03 + i));
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 check($sformatf("rr.grant%0d", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      if (k >= 1) begin
        check($sformatf("rr.valid%0d", k), 64'(bus.rsp_valid), 64'd1);
        check($sformatf("rr.id%0d", k), 64'(bus.rsp_id), 64'((k - 1) % 4));
        check($sformatf("rr.prod%0d", k), 64'(bus.rsp_prod), 64'(rr_prod[(k - 1) % 4]));
      end
    end
    bus.req_valid = '0;
    tick();
    check("rr.last_id", 64'(bus.rsp_id), 64'd3);
    check("rr.last_prod", 64'(bus.rsp_prod), 64'h0072);
    tick();
    check("rr.idle", 64'(bus.busy), 64'd0);

    // Backpressure: 5 stalled cycles admit exactly two operands.
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (|bus.req_ready) n_acc++;
      if (k >= 2) check($sformatf("bp.ready%0d", k), 64'(bus.req_ready), 64'd0);
      tick();
      if (k >= 1) begin
        check($sformatf("bp.valid%0d", k), 64'(bus.rsp_valid), 64'd1);
        check($sformatf("bp.prod%0d", k), 64'(bus.rsp_prod), 64'h0030);
        check($sformatf("bp.id%0d", k), 64'(bus.rsp_id), 64'd0);
      end
    end
    check("bp.accepts", 64'(n_acc), 64'd2);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    #1 check("bp.drain0_prod", 64'(bus.rsp_prod), 64'h0030);
    tick();
    check("bp.drain1_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp.drain1_prod", 64'(bus.rsp_prod), 64'h0044);
    check("bp.drain1_id", 64'(bus.rsp_id), 64'd1);
    tick();
    check("bp.drained", 64'(bus.rsp_valid), 64'd0);
    check("bp.idle", 64'(bus.busy), 64'd0);

    // Reset while both stages hold data; pointer is at 2 here.
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    #1 check("mr.grant2", 64'(bus.req_ready), 64'b0100);
    tick();
    tick();
    check("mr.full_busy", 64'(bus.busy), 64'd1);
    check("mr.full_id", 64'(bus.rsp_id), 64'd2);
    rst = 1'b1;
    #1 check("mr.ready_in_rst", 64'(bus.req_ready), 64'd0);
    check("mr.valid_in_rst", 64'(bus.rsp_valid), 64'd0);
    tick();
    rst = 1'b0;
    #1 check("mr.valid", 64'(bus.rsp_valid), 64'd0);
    check("mr.busy", 64'(bus.busy), 64'd0);
    check("mr.grant0", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    check("mr.rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("mr.rsp_id", 64'(bus.rsp_id), 64'd0);
    check("mr.rsp_prod", 64'(bus.rsp_prod), 64'h0030);
    tick();
    check("mr.idle", 64'(bus.busy), 64'd0);

`ifdef DADDA_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("st.cleared", grant_cnt, 64'd0);
    bus.req_valid = 4'b0010;
    repeat (10) tick();
    bus.req_valid = 4'b1000;
    repeat (3) tick();
    bus.req_valid = '0;
    tick();
    tick();
    check("st.cnt1", 64'(grant_cnt[31:16]), 64'd10);
    check("st.cnt3", 64'(grant_cnt[63:48]), 64'd3);
    check("st.cnt0", 64'(grant_cnt[15:0]), 64'd0);
    bus.req_valid = 4'b0010;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    bus.req_valid = '0;
    check("st.clr_wins", grant_cnt, 64'd0);
    tick();
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
